// File: rtl/pipeline_pkg.sv
// Shared encodings for the fetch-stage redirect controller: status codes,
// one-hot next-PC selects, hard-wired fetch vectors and the EPC increment.
package pipeline_pkg;

    typedef enum logic [1:0] {
        STATUS_NORMAL = 2'b00,
        STATUS_RESET  = 2'b01,
        STATUS_IRQ    = 2'b10,
        STATUS_EXC    = 2'b11
    } status_e;

    localparam logic [2:0] SEL_SEQ = 3'b000;
    localparam logic [2:0] SEL_BR  = 3'b100;
    localparam logic [2:0] SEL_J   = 3'b010;
    localparam logic [2:0] SEL_JR  = 3'b001;

    localparam logic [31:0] VEC_RESET = 32'h0000_0000;
    localparam logic [31:0] VEC_IRQ   = 32'h0000_0004;
    localparam logic [31:0] VEC_EXC   = 32'h0000_0008;

    // Next-cycle redirect decision, in priority order.
    typedef enum logic [3:0] {
        D_SEQ,
        D_SRST,
        D_EXC,
        D_BR,
        D_ERET,
        D_JUMP,
        D_JR,
        D_IRQ,
        D_STALL
    } decision_e;

endpackage

// File: rtl/if_redirect_ctrl_epc_reg.sv
// EPC and kernel-mode flag. The saved return address keeps bit 31 (kernel
// segment) and wraps the +4 within the low 31 bits.
module epc_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         capture,
    input  logic [W-1:0] ret_pc,
    input  logic         enter_kernel,
    input  logic         leave_kernel,
    output logic [W-1:0] epc,
    output logic         in_kernel
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc       <= '0;
            in_kernel <= 1'b0;
        end else begin
            if (capture)
                epc <= {ret_pc[W-1], ret_pc[W-2:0] + (W-1)'(4)};
            if (enter_kernel)
                in_kernel <= 1'b1;
            else if (leave_kernel)
                in_kernel <= 1'b0;
        end
    end

endmodule

// File: rtl/if_redirect_ctrl.sv
// Instruction-fetch redirect controller: one prioritised next-PC decision per
// cycle, plus the pending-interrupt latch, EPC and kernel-mode state.
module if_redirect_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RST_VEC = 32'h0000_0000,
    parameter int unsigned EPC_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sys_rst_req,
    input  logic             exc_req,
    input  logic             irq,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             jr,
    input  logic             eret,
    input  logic             load_use,
    input  logic [31:0]      pc_if,
    input  logic [31:0]      pc_id,
    output logic             pc_if_id_write,
    output logic [2:0]       select_pc_next,
    output logic [1:0]       status,
    output logic             kill_id,
    output logic             kill_ex,
    output logic             jr_from_epc,
    output logic [EPC_W-1:0] epc,
    output logic             in_kernel
);

    // The fetch stage hard-codes its vectors; a mismatched override is a build error.
    if (RST_VEC != VEC_RESET) begin : g_rst_vec_check
        $error("RST_VEC must equal the fetch-stage reset vector");
    end

    decision_e decision;
    status_e   st;
    logic      irq_pend;
    logic      capture;
    logic      enter_kernel;
    logic      leave_kernel;
    logic [31:0] ret_pc;

    always_comb begin
        decision = D_SEQ;
        if (sys_rst_req)
            decision = D_SRST;
        else if (exc_req)
            decision = D_EXC;
        else if (branch_taken)
            decision = D_BR;
        else if (eret)
            decision = D_ERET;
        else if (jump)
            decision = D_JUMP;
        else if (jr)
            decision = D_JR;
        else if (irq_pend && !in_kernel && !load_use)
            decision = D_IRQ;
        else if (load_use)
            decision = D_STALL;
    end

    always_comb begin
        pc_if_id_write = 1'b1;
        select_pc_next = SEL_SEQ;
        st             = STATUS_NORMAL;
        kill_id        = 1'b0;
        kill_ex        = 1'b0;
        jr_from_epc    = 1'b0;
        capture        = 1'b0;
        enter_kernel   = 1'b0;
        leave_kernel   = 1'b0;
        unique case (decision)
            D_SRST: begin
                st           = STATUS_RESET;
                kill_id      = 1'b1;
                kill_ex      = 1'b1;
                leave_kernel = 1'b1;
            end
            D_EXC: begin
                st           = STATUS_EXC;
                kill_id      = 1'b1;
                kill_ex      = 1'b1;
                capture      = 1'b1;
                enter_kernel = 1'b1;
            end
            D_BR: begin
                select_pc_next = SEL_BR;
                kill_id        = 1'b1;
            end
            // eret outside kernel mode degrades to an ordinary jr
            D_ERET: begin
                select_pc_next = SEL_JR;
                kill_id        = 1'b1;
                jr_from_epc    = in_kernel;
                leave_kernel   = in_kernel;
            end
            D_JUMP: begin
                select_pc_next = SEL_J;
                kill_id        = 1'b1;
            end
            D_JR: begin
                select_pc_next = SEL_JR;
                kill_id        = 1'b1;
            end
            D_IRQ: begin
                st           = STATUS_IRQ;
                capture      = 1'b1;
                enter_kernel = 1'b1;
            end
            D_STALL: begin
                pc_if_id_write = 1'b0;
                kill_ex        = 1'b1;
            end
            default: ;
        endcase
    end

    assign status = st;
    assign ret_pc = (decision == D_EXC) ? pc_id : pc_if;

    // An irq arriving in the cycle the interrupt is taken (or a soft reset) is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_pend <= 1'b0;
        else if (decision == D_SRST || decision == D_IRQ)
            irq_pend <= 1'b0;
        else if (irq)
            irq_pend <= 1'b1;
    end

    epc_reg #(
        .W(EPC_W)
    ) u_epc_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture      (capture),
        .ret_pc       (EPC_W'(ret_pc)),
        .enter_kernel (enter_kernel),
        .leave_kernel (leave_kernel),
        .epc          (epc),
        .in_kernel    (in_kernel)
    );

endmodule

// File: tb/tb_if_redirect_ctrl.sv
// Directed bench for if_redirect_ctrl; control outputs are compared as one
// packed vector {write, select[2:0], status[1:0], kill_id, kill_ex, jr_from_epc}.
module tb_if_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sys_rst_req, exc_req, irq, branch_taken, jump, jr, eret, load_use;
    logic [31:0] pc_if, pc_id;
    logic        pc_if_id_write;
    logic [2:0]  select_pc_next;
    logic [1:0]  status;
    logic        kill_id, kill_ex, jr_from_epc;
    logic [31:0] epc;
    logic        in_kernel;
    logic [8:0]  ctl;

    int passed = 0;
    int total  = 0;

    localparam logic [8:0] C_NORM  = 9'b1_000_00_000;
    localparam logic [8:0] C_IRQ   = 9'b1_000_10_000;
    localparam logic [8:0] C_EXC   = 9'b1_000_11_110;
    localparam logic [8:0] C_SRST  = 9'b1_000_01_110;
    localparam logic [8:0] C_BR    = 9'b1_100_00_100;
    localparam logic [8:0] C_J     = 9'b1_010_00_100;
    localparam logic [8:0] C_JR    = 9'b1_001_00_100;
    localparam logic [8:0] C_ERET  = 9'b1_001_00_101;
    localparam logic [8:0] C_STALL = 9'b0_000_00_010;

    if_redirect_ctrl #(
        .RST_VEC (32'h0000_0000),
        .EPC_W   (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sys_rst_req    (sys_rst_req),
        .exc_req        (exc_req),
        .irq            (irq),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .jr             (jr),
        .eret           (eret),
        .load_use       (load_use),
        .pc_if          (pc_if),
        .pc_id          (pc_id),
        .pc_if_id_write (pc_if_id_write),
        .select_pc_next (select_pc_next),
        .status         (status),
        .kill_id        (kill_id),
        .kill_ex        (kill_ex),
        .jr_from_epc    (jr_from_epc),
        .epc            (epc),
        .in_kernel      (in_kernel)
    );

    assign ctl = {pc_if_id_write, select_pc_next, status, kill_id, kill_ex, jr_from_epc};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sys_rst_req = 0; exc_req = 0; irq = 0; branch_taken = 0;
        jump = 0; jr = 0; eret = 0; load_use = 0;
    endtask

    task automatic leave_kernel();
        idle(); eret = 1; tick(); idle();
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); pc_if = 0; pc_id = 0;
        #12;
        total++; if (ctl !== C_NORM) $display("FAIL reset_ctl got %b exp %b", ctl, C_NORM); else passed++;
        total++; if (epc !== 32'h0) $display("FAIL reset_epc got %h exp %h", epc, 32'h0); else passed++;
        total++; if (in_kernel !== 1'b0) $display("FAIL reset_kernel got %b exp %b", in_kernel, 1'b0); else passed++;
        @(negedge clk); rst_n = 1;
        tick();
    endtask

    task automatic test_irq_idle();
        idle(); pc_if = 32'h40; irq = 1; #1;
        total++; if (ctl !== C_NORM) $display("FAIL irq_latch_cycle got %b exp %b", ctl, C_NORM); else passed++;
        tick(); irq = 0; #1;
        total++; if (ctl !== C_IRQ) $display("FAIL irq_take got %b exp %b", ctl, C_IRQ); else passed++;
        tick();
        total++; if (epc !== 32'h44) $display("FAIL irq_epc got %h exp %h", epc, 32'h44); else passed++;
        total++; if (in_kernel !== 1'b1) $display("FAIL irq_kernel got %b exp %b", in_kernel, 1'b1); else passed++;
        eret = 1; #1;
        total++; if (ctl !== C_ERET) $display("FAIL eret_kernel got %b exp %b", ctl, C_ERET); else passed++;
        tick(); eret = 0; #1;
        total++; if (in_kernel !== 1'b0) $display("FAIL eret_leave got %b exp %b", in_kernel, 1'b0); else passed++;
    endtask

    task automatic test_irq_vs_jump();
        idle(); irq = 1; tick();
        irq = 0; jump = 1; #1;
        total++; if (ctl !== C_J) $display("FAIL irq_vs_jump got %b exp %b", ctl, C_J); else passed++;
        tick(); jump = 0; pc_if = 32'h100; #1;
        total++; if (ctl !== C_IRQ) $display("FAIL irq_after_jump got %b exp %b", ctl, C_IRQ); else passed++;
        tick();
        total++; if (epc !== 32'h104) $display("FAIL irq_after_jump_epc got %h exp %h", epc, 32'h104); else passed++;
        leave_kernel();
    endtask

    task automatic test_exc_branch();
        idle(); exc_req = 1; branch_taken = 1; load_use = 1; pc_id = 32'h8000_0010; #1;
        total++; if (ctl !== C_EXC) $display("FAIL exc_over_branch got %b exp %b", ctl, C_EXC); else passed++;
        tick(); idle(); #1;
        total++; if (epc !== 32'h8000_0014) $display("FAIL exc_epc got %h exp %h", epc, 32'h8000_0014); else passed++;
        total++; if (in_kernel !== 1'b1) $display("FAIL exc_kernel got %b exp %b", in_kernel, 1'b1); else passed++;
    endtask

    task automatic test_kernel_irq_eret();
        idle(); irq = 1; tick();
        irq = 0; #1;
        total++; if (ctl !== C_NORM) $display("FAIL irq_held_in_kernel got %b exp %b", ctl, C_NORM); else passed++;
        tick(); eret = 1; #1;
        total++; if (ctl !== C_ERET) $display("FAIL eret_pending got %b exp %b", ctl, C_ERET); else passed++;
        tick(); eret = 0; pc_if = 32'h200; irq = 1; #1;
        total++; if (ctl !== C_IRQ) $display("FAIL irq_after_eret got %b exp %b", ctl, C_IRQ); else passed++;
        tick(); irq = 0; #1;
        total++; if (epc !== 32'h204) $display("FAIL irq_after_eret_epc got %h exp %h", epc, 32'h204); else passed++;
        leave_kernel(); #1;
        total++; if (ctl !== C_NORM) $display("FAIL irq_same_cycle_dropped got %b exp %b", ctl, C_NORM); else passed++;
    endtask

    task automatic test_epc_wrap();
        idle(); exc_req = 1; pc_id = 32'hFFFF_FFFC; tick(); idle(); #1;
        total++; if (epc !== 32'h8000_0000) $display("FAIL epc_wrap_kseg got %h exp %h", epc, 32'h8000_0000); else passed++;
        leave_kernel();
        exc_req = 1; pc_id = 32'h7FFF_FFFC; tick(); idle(); #1;
        total++; if (epc !== 32'h0000_0000) $display("FAIL epc_wrap_user got %h exp %h", epc, 32'h0); else passed++;
        leave_kernel();
        eret = 1; #1;
        total++; if (ctl !== C_JR) $display("FAIL eret_user_as_jr got %b exp %b", ctl, C_JR); else passed++;
        tick(); idle(); jr = 1; #1;
        total++; if (ctl !== C_JR) $display("FAIL jr got %b exp %b", ctl, C_JR); else passed++;
        tick(); idle();
    endtask

    task automatic test_load_use();
        idle(); load_use = 1; #1;
        total++; if (ctl !== C_STALL) $display("FAIL load_use_alone got %b exp %b", ctl, C_STALL); else passed++;
        branch_taken = 1; #1;
        total++; if (ctl !== C_BR) $display("FAIL load_use_branch got %b exp %b", ctl, C_BR); else passed++;
        branch_taken = 0; irq = 1; tick();
        irq = 0; #1;
        total++; if (ctl !== C_STALL) $display("FAIL irq_blocked_by_stall got %b exp %b", ctl, C_STALL); else passed++;
        load_use = 0; pc_if = 32'h300; #1;
        total++; if (ctl !== C_IRQ) $display("FAIL irq_after_stall got %b exp %b", ctl, C_IRQ); else passed++;
        tick();
        leave_kernel();
    endtask

    task automatic test_soft_reset();
        idle(); exc_req = 1; pc_id = 32'h10; tick(); idle();
        irq = 1; tick(); irq = 0;
        sys_rst_req = 1; #1;
        total++; if (ctl !== C_SRST) $display("FAIL soft_reset got %b exp %b", ctl, C_SRST); else passed++;
        tick(); sys_rst_req = 0; #1;
        total++; if (in_kernel !== 1'b0) $display("FAIL soft_reset_kernel got %b exp %b", in_kernel, 1'b0); else passed++;
        total++; if (epc !== 32'h14) $display("FAIL soft_reset_epc got %h exp %h", epc, 32'h14); else passed++;
        total++; if (ctl !== C_NORM) $display("FAIL soft_reset_no_irq got %b exp %b", ctl, C_NORM); else passed++;
        tick();
        total++; if (ctl !== C_NORM) $display("FAIL soft_reset_no_irq2 got %b exp %b", ctl, C_NORM); else passed++;
    endtask

    task automatic test_async_reset();
        idle(); irq = 1; tick(); irq = 0;
        @(negedge clk); rst_n = 0; #1;
        total++; if (epc !== 32'h0) $display("FAIL async_reset_epc got %h exp %h", epc, 32'h0); else passed++;
        total++; if (ctl !== C_NORM) $display("FAIL async_reset_ctl got %b exp %b", ctl, C_NORM); else passed++;
        rst_n = 1;
        tick();
        total++; if (ctl !== C_NORM) $display("FAIL async_reset_irq_lost got %b exp %b", ctl, C_NORM); else passed++;
    endtask

    initial begin
        test_reset();
        test_irq_idle();
        test_irq_vs_jump();
        test_exc_branch();
        test_kernel_irq_eret();
        test_epc_wrap();
        test_load_use();
        test_soft_reset();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
